// File: rtl/pic_init_sequencer_if.sv
// -----------------------------------------------------------------------------
// pic_init_sequencer_if
//   CPU write-bus bundle for the PIC command-word sequencer.
//
//   Signals
//     wr_stb  one-cycle write strobe, already synchronized to clk
//     a0      address bit A0 qualifying the write
//     din     write data D7..D0
//
//   Modports
//     master  CPU side (drives the bus)
//     slave   sequencer side (samples the bus)
// -----------------------------------------------------------------------------
interface pic_init_sequencer_if;
    logic       wr_stb;
    logic       a0;
    logic [7:0] din;

    modport master (output wr_stb, output a0, output din);
    modport slave  (input  wr_stb, input  a0, input  din);
endinterface : pic_init_sequencer_if

// File: rtl/pic_init_sequencer.sv
// -----------------------------------------------------------------------------
// pic_init_sequencer
//   Command-word sequencer for an 8259A-compatible PIC. Decodes CPU writes
//   (A0 + 8-bit data) into the ICW1..ICW4 initialization sequence and the
//   OCW1..OCW3 operational commands. Owns the interrupt mask register and
//   publishes the configuration fields used by the priority resolver and the
//   ISR/IRR logic.
//
//   Parameters
//     MASK_RESET_VAL  mask value loaded by rst (ICW1 always clears to 8'h00)
//
//   Ports
//     clk          system clock, all state on the rising edge
//     rst          synchronous, active-high reset
//     bus          write bus (wr_stb, a0, din), slave side
//     mask         current IMR value (1 = IRn masked)
//     mask_clr     pulse: mask cleared by ICW1
//     mask_we      pulse: mask loaded by OCW1
//     vector_base  T7..T3 from ICW2
//     icw3         cascade word from ICW3
//     sngl/ic4/ltim               ICW1 D1/D0/D3
//     upm/aeoi/ms/buf_mode/sfnm   ICW4 D0/D1/D2/D3/D4
//     init_done    high while the sequencer is in the ready state
//     ocw2_stb     pulse: OCW2 accepted
//     ocw2_cmd     OCW2 R,SL,EOI (D7..D5)
//     ocw2_lvl     OCW2 L2..L0
//     read_isr     OCW3 RIS state (0 = read IRR, 1 = read ISR)
//     smm          special mask mode
//     poll_stb     pulse: OCW3 poll command
//     cmd_err      pulse: write ignored as illegal for the current state
//
//   Every output is a register; the effect of a write appears on the cycle
//   after its wr_stb cycle. Pulses are cleared on every cycle they are not
//   re-asserted, so back-to-back writes give back-to-back pulses.
// -----------------------------------------------------------------------------
module pic_init_sequencer #(
    parameter logic [7:0] MASK_RESET_VAL = 8'h00
) (
    input  logic                        clk,
    input  logic                        rst,
    pic_init_sequencer_if.slave         bus,
    output logic [7:0]                  mask,
    output logic                        mask_clr,
    output logic                        mask_we,
    output logic [4:0]                  vector_base,
    output logic [7:0]                  icw3,
    output logic                        sngl,
    output logic                        ic4,
    output logic                        ltim,
    output logic                        upm,
    output logic                        aeoi,
    output logic                        ms,
    output logic                        buf_mode,
    output logic                        sfnm,
    output logic                        init_done,
    output logic                        ocw2_stb,
    output logic [2:0]                  ocw2_cmd,
    output logic [2:0]                  ocw2_lvl,
    output logic                        read_isr,
    output logic                        smm,
    output logic                        poll_stb,
    output logic                        cmd_err
);

    typedef enum logic [2:0] {
        S_ICW1  = 3'd0,
        S_ICW2  = 3'd1,
        S_ICW3  = 3'd2,
        S_ICW4  = 3'd3,
        S_READY = 3'd4
    } state_t;

    state_t      state_q;
    logic [7:0]  mask_q;
    logic        mask_clr_q;
    logic        mask_we_q;
    logic [4:0]  vector_base_q;
    logic [7:0]  icw3_q;
    logic        sngl_q;
    logic        ic4_q;
    logic        ltim_q;
    logic        upm_q;
    logic        aeoi_q;
    logic        ms_q;
    logic        buf_mode_q;
    logic        sfnm_q;
    logic        init_done_q;
    logic        ocw2_stb_q;
    logic [2:0]  ocw2_cmd_q;
    logic [2:0]  ocw2_lvl_q;
    logic        read_isr_q;
    logic        smm_q;
    logic        poll_stb_q;
    logic        cmd_err_q;

    // ICW1 is recognised in every state, so it is decoded ahead of the
    // per-state handling and restarts the sequence whenever it appears.
    logic is_icw1;
    assign is_icw1 = bus.wr_stb & ~bus.a0 & bus.din[4];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_ICW1;
            mask_q        <= MASK_RESET_VAL;
            mask_clr_q    <= 1'b0;
            mask_we_q     <= 1'b0;
            vector_base_q <= '0;
            icw3_q        <= '0;
            sngl_q        <= 1'b0;
            ic4_q         <= 1'b0;
            ltim_q        <= 1'b0;
            upm_q         <= 1'b0;
            aeoi_q        <= 1'b0;
            ms_q          <= 1'b0;
            buf_mode_q    <= 1'b0;
            sfnm_q        <= 1'b0;
            init_done_q   <= 1'b0;
            ocw2_stb_q    <= 1'b0;
            ocw2_cmd_q    <= '0;
            ocw2_lvl_q    <= '0;
            read_isr_q    <= 1'b0;
            smm_q         <= 1'b0;
            poll_stb_q    <= 1'b0;
            cmd_err_q     <= 1'b0;
        end else begin
            mask_clr_q <= 1'b0;
            mask_we_q  <= 1'b0;
            ocw2_stb_q <= 1'b0;
            poll_stb_q <= 1'b0;
            cmd_err_q  <= 1'b0;

            if (is_icw1) begin
                ic4_q       <= bus.din[0];
                sngl_q      <= bus.din[1];
                ltim_q      <= bus.din[3];
                mask_q      <= 8'h00;
                mask_clr_q  <= 1'b1;
                upm_q       <= 1'b0;
                aeoi_q      <= 1'b0;
                ms_q        <= 1'b0;
                buf_mode_q  <= 1'b0;
                sfnm_q      <= 1'b0;
                read_isr_q  <= 1'b0;
                smm_q       <= 1'b0;
                init_done_q <= 1'b0;
                state_q     <= S_ICW2;
            end else if (bus.wr_stb) begin
                case (state_q)
                    S_ICW2: begin
                        if (bus.a0) begin
                            vector_base_q <= bus.din[7:3];
                            // Single mode skips ICW3; no IC4 skips ICW4.
                            if (!sngl_q) begin
                                state_q <= S_ICW3;
                            end else if (ic4_q) begin
                                state_q <= S_ICW4;
                            end else begin
                                state_q     <= S_READY;
                                init_done_q <= 1'b1;
                            end
                        end else begin
                            cmd_err_q <= 1'b1;
                        end
                    end
                    S_ICW3: begin
                        if (bus.a0) begin
                            icw3_q <= bus.din;
                            if (ic4_q) begin
                                state_q <= S_ICW4;
                            end else begin
                                state_q     <= S_READY;
                                init_done_q <= 1'b1;
                            end
                        end else begin
                            cmd_err_q <= 1'b1;
                        end
                    end
                    S_ICW4: begin
                        if (bus.a0) begin
                            upm_q       <= bus.din[0];
                            aeoi_q      <= bus.din[1];
                            ms_q        <= bus.din[2];
                            buf_mode_q  <= bus.din[3];
                            sfnm_q      <= bus.din[4];
                            state_q     <= S_READY;
                            init_done_q <= 1'b1;
                        end else begin
                            cmd_err_q <= 1'b1;
                        end
                    end
                    S_READY: begin
                        if (bus.a0) begin
                            mask_q    <= bus.din;
                            mask_we_q <= 1'b1;
                        end else if (!bus.din[3]) begin
                            // din[4] is known clear here (ICW1 taken above),
                            // so din[3] alone separates OCW2 from OCW3.
                            ocw2_cmd_q <= bus.din[7:5];
                            ocw2_lvl_q <= bus.din[2:0];
                            ocw2_stb_q <= 1'b1;
                        end else begin
                            if (bus.din[1]) begin
                                read_isr_q <= bus.din[0];
                            end
                            if (bus.din[6]) begin
                                smm_q <= bus.din[5];
                            end
                            poll_stb_q <= bus.din[2];
                        end
                    end
                    default: begin
                        // Uninitialized: only ICW1 is legal.
                        cmd_err_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign mask        = mask_q;
    assign mask_clr    = mask_clr_q;
    assign mask_we     = mask_we_q;
    assign vector_base = vector_base_q;
    assign icw3        = icw3_q;
    assign sngl        = sngl_q;
    assign ic4         = ic4_q;
    assign ltim        = ltim_q;
    assign upm         = upm_q;
    assign aeoi        = aeoi_q;
    assign ms          = ms_q;
    assign buf_mode    = buf_mode_q;
    assign sfnm        = sfnm_q;
    assign init_done   = init_done_q;
    assign ocw2_stb    = ocw2_stb_q;
    assign ocw2_cmd    = ocw2_cmd_q;
    assign ocw2_lvl    = ocw2_lvl_q;
    assign read_isr    = read_isr_q;
    assign smm         = smm_q;
    assign poll_stb    = poll_stb_q;
    assign cmd_err     = cmd_err_q;

endmodule : pic_init_sequencer

// File: tb/tb_pic_init_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pic_init_sequencer
//   Directed scoreboard bench. Each stimulus cycle pushes the hand-computed
//   expected output snapshot; a monitor pops and compares one cycle later.
// -----------------------------------------------------------------------------
module tb_pic_init_sequencer;

    typedef struct packed {
        logic [7:0] mask;
        logic       mask_clr;
        logic       mask_we;
        logic [4:0] vb;
        logic [7:0] icw3;
        logic       sngl;
        logic       ic4;
        logic       ltim;
        logic       upm;
        logic       aeoi;
        logic       ms;
        logic       buf_mode;
        logic       sfnm;
        logic       init_done;
        logic       ocw2_stb;
        logic [2:0] ocw2_cmd;
        logic [2:0] ocw2_lvl;
        logic       read_isr;
        logic       smm;
        logic       poll_stb;
        logic       cmd_err;
    } obs_t;

    typedef struct {
        string name;
        obs_t  v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pic_init_sequencer_if bus_if ();

    logic [7:0] mask;
    logic       mask_clr, mask_we;
    logic [4:0] vector_base;
    logic [7:0] icw3;
    logic       sngl, ic4, ltim, upm, aeoi, ms, buf_mode, sfnm, init_done;
    logic       ocw2_stb;
    logic [2:0] ocw2_cmd, ocw2_lvl;
    logic       read_isr, smm, poll_stb, cmd_err;

    pic_init_sequencer #(.MASK_RESET_VAL(8'hFF)) dut (
        .clk(clk), .rst(rst), .bus(bus_if.slave),
        .mask(mask), .mask_clr(mask_clr), .mask_we(mask_we),
        .vector_base(vector_base), .icw3(icw3),
        .sngl(sngl), .ic4(ic4), .ltim(ltim),
        .upm(upm), .aeoi(aeoi), .ms(ms), .buf_mode(buf_mode), .sfnm(sfnm),
        .init_done(init_done), .ocw2_stb(ocw2_stb), .ocw2_cmd(ocw2_cmd),
        .ocw2_lvl(ocw2_lvl), .read_isr(read_isr), .smm(smm),
        .poll_stb(poll_stb), .cmd_err(cmd_err)
    );

    obs_t act;
    assign act = '{mask, mask_clr, mask_we, vector_base, icw3, sngl, ic4, ltim,
                   upm, aeoi, ms, buf_mode, sfnm, init_done, ocw2_stb,
                   ocw2_cmd, ocw2_lvl, read_isr, smm, poll_stb, cmd_err};

    exp_t q[$];
    obs_t e;
    int   total = 0;
    int   bad   = 0;
    logic issued = 1'b0;
    logic chk    = 1'b0;

    always @(posedge clk) chk <= issued;

    // Monitor: a DUT response is due on every cycle after an issued cycle.
    always @(negedge clk) begin
        if (chk) begin
            exp_t x;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL underflow: got %h, required an expectation entry", act);
            end else begin
                x = q.pop_front();
                if (act !== x.v) begin
                    bad++;
                    $display("FAIL %s: got %h required %h", x.name, act, x.v);
                end
            end
        end
    end

    // Drive one cycle and queue its expectation, then drop the pulse fields
    // from the running expectation so idle cycles check they fall.
    task automatic step(input logic r, input logic w, input logic a,
                        input logic [7:0] d, input string nm);
        exp_t x;
        @(negedge clk);
        rst = r;
        bus_if.wr_stb = w;
        bus_if.a0 = a;
        bus_if.din = d;
        issued = 1'b1;
        x.name = nm;
        x.v = e;
        q.push_back(x);
        e.mask_clr = 1'b0;
        e.mask_we  = 1'b0;
        e.ocw2_stb = 1'b0;
        e.poll_stb = 1'b0;
        e.cmd_err  = 1'b0;
    endtask

    task automatic wr(input logic a, input logic [7:0] d, input string nm);
        step(1'b0, 1'b1, a, d, nm);
    endtask

    task automatic idle(input string nm);
        step(1'b0, 1'b0, 1'b0, 8'h00, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.wr_stb = 1'b0;
        bus_if.a0 = 1'b0;
        bus_if.din = 8'h00;
        e = '0;

        // Reset with MASK_RESET_VAL = FF
        e.mask = 8'hFF;
        step(1'b1, 1'b0, 1'b0, 8'h00, "reset");
        e.cmd_err = 1'b1;                       wr(1'b1, 8'h55, "err_uninit");
        idle("err_pulse_drop");

        // Single, IC4: ICW1 13, ICW2 08, ICW4 03 (ICW3 skipped)
        e.sngl = 1; e.ic4 = 1; e.mask = 8'h00; e.mask_clr = 1;
        wr(1'b0, 8'h13, "icw1_13");
        idle("clr_pulse_drop");
        e.vb = 5'h01;                           wr(1'b1, 8'h08, "icw2_08");
        e.upm = 1; e.aeoi = 1; e.init_done = 1; wr(1'b1, 8'h03, "icw4_03");

        // Cascade with ICW3 and ICW4: 11, 20, 04, 01
        e.sngl = 0; e.ic4 = 1; e.mask_clr = 1; e.upm = 0; e.aeoi = 0; e.init_done = 0;
        wr(1'b0, 8'h11, "icw1_11");
        e.vb = 5'h04;                           wr(1'b1, 8'h20, "icw2_20");
        e.icw3 = 8'h04;                         wr(1'b1, 8'h04, "icw3_04");
        e.upm = 1; e.init_done = 1;             wr(1'b1, 8'h01, "icw4_01");

        // Cascade without ICW4: 10, 20, (illegal), 04
        e.ic4 = 0; e.mask_clr = 1; e.upm = 0; e.init_done = 0;
        wr(1'b0, 8'h10, "icw1_10");
        wr(1'b1, 8'h20, "icw2_20b");
        e.cmd_err = 1;                          wr(1'b0, 8'h00, "err_icw3");
        e.init_done = 1;                        wr(1'b1, 8'h04, "icw3_ready");

        // Operational commands
        e.mask = 8'hF0; e.mask_we = 1;          wr(1'b1, 8'hF0, "ocw1_f0");
        e.mask = 8'h0F; e.mask_we = 1;          wr(1'b1, 8'h0F, "ocw1_0f");
        idle("we_pulse_drop");
        e.ocw2_cmd = 3; e.ocw2_lvl = 3; e.ocw2_stb = 1;
        wr(1'b0, 8'h63, "ocw2_63");
        e.ocw2_cmd = 0; e.ocw2_lvl = 0; e.ocw2_stb = 1;
        wr(1'b0, 8'h00, "ocw2_00");
        e.read_isr = 1;                         wr(1'b0, 8'h0B, "ocw3_0b");
        e.smm = 1;                              wr(1'b0, 8'h68, "ocw3_68");
        e.poll_stb = 1;                         wr(1'b0, 8'h0C, "ocw3_0c");
        idle("poll_pulse_drop");
        e.mask = 8'hAA; e.mask_we = 1;          wr(1'b1, 8'hAA, "ocw1_aa");

        // Re-init from READY clears mask, read_isr, smm, init_done
        e.mask = 8'h00; e.mask_clr = 1; e.sngl = 1; e.ic4 = 1;
        e.read_isr = 0; e.smm = 0; e.init_done = 0;
        wr(1'b0, 8'h13, "reinit_ready");

        // Mid-sequence restart: 11, ICW2, then 13 -> back in ICW2
        e.sngl = 0; e.mask_clr = 1;             wr(1'b0, 8'h11, "restart_icw1");
        e.vb = 5'h01;                           wr(1'b1, 8'h08, "restart_icw2");
        e.sngl = 1; e.mask_clr = 1;             wr(1'b0, 8'h13, "restart_again");
        e.vb = 5'h08;                           wr(1'b1, 8'h40, "restart_in_icw2");
        e.upm = 1; e.aeoi = 1; e.ms = 1; e.buf_mode = 1; e.sfnm = 1; e.init_done = 1;
        wr(1'b1, 8'h1F, "icw4_1f");

        // LTIM, single, no IC4: 1A then ICW2 goes straight to READY
        e.ltim = 1; e.sngl = 1; e.ic4 = 0; e.mask_clr = 1; e.init_done = 0;
        e.upm = 0; e.aeoi = 0; e.ms = 0; e.buf_mode = 0; e.sfnm = 0;
        wr(1'b0, 8'h1A, "icw1_1a");
        e.vb = 5'h1F; e.init_done = 1;          wr(1'b1, 8'hF8, "icw2_direct");

        // Reset in ICW3 coincident with a write
        e.ltim = 0; e.sngl = 0; e.mask_clr = 1; e.init_done = 0;
        wr(1'b0, 8'h10, "icw1_pre_rst");
        e.vb = 5'h04;                           wr(1'b1, 8'h20, "icw2_pre_rst");
        e = '0; e.mask = 8'hFF;
        step(1'b1, 1'b1, 1'b1, 8'h77, "rst_with_wr");
        e.cmd_err = 1;                          wr(1'b1, 8'h33, "post_rst_uninit");

        @(negedge clk);
        issued = 1'b0;
        bus_if.wr_stb = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL leftover: got %0d pending entries, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pic_init_sequencer
